// File: rtl/mcdf_pkt_arbiter.sv
// mcdf_pkt_arbiter: picks one MCDF channel by priority and round robin, then streams one packet to the formatter.
// Optional grant timeout is enabled with MCDF_ARB_TIMEOUT_EN.
module mcdf_pkt_arbiter #(
  parameter int DW = 32,
  parameter int LW = 6
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [2:0]    slv_en_i,
  input  logic [2:0]    slv_req_i,
  input  logic [5:0]    slv_prio_i,
  input  logic [8:0]    slv_len_i,
  input  logic [DW-1:0] slv0_data_i,
  input  logic [DW-1:0] slv1_data_i,
  input  logic [DW-1:0] slv2_data_i,
  input  logic [2:0]    slv_val_i,
  output logic [2:0]    slv_ack_o,
  output logic          fmt_req_o,
  input  logic          fmt_grant_i,
  output logic [1:0]    fmt_chid_o,
  output logic [LW-1:0] fmt_length_o,
  output logic          fmt_val_o,
  output logic [DW-1:0] fmt_data_o,
  output logic          fmt_start_o,
  output logic          fmt_end_o,
  output logic          arb_timeout_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_chid, r_last;
  logic [LW-1:0] r_len, r_cnt, w_len_dec;
  logic [DW-1:0] r_data, w_data;
  logic          r_val, r_start, r_end;
  logic [2:0]    w_cand;
  logic [1:0]    w_o0, w_o1, w_o2, w_c, w_win, w_best;
  logic [5:0]    w_ord;
  logic          w_found, w_xfer, w_last_word, w_take;
`ifdef MCDF_ARB_TIMEOUT_EN
  logic [9:0]    r_to_cnt;
  logic          r_timeout, w_timeout;
`endif

  function automatic logic [LW-1:0] dec_len(input logic [2:0] code);
    return code == 3'd0 ? LW'(4) : code == 3'd1 ? LW'(8) : code == 3'd2 ? LW'(16) : LW'(32);
  endfunction

  assign w_cand = slv_en_i & slv_req_i;
  // tie-break order starts at the channel after the last winner
  assign w_o0   = r_last == 2'd2 ? 2'd0 : r_last + 2'd1;
  assign w_o1   = w_o0 == 2'd2 ? 2'd0 : w_o0 + 2'd1;
  assign w_o2   = w_o1 == 2'd2 ? 2'd0 : w_o1 + 2'd1;
  assign w_ord  = {w_o2, w_o1, w_o0};

  always_comb begin
    w_found = 1'b0;
    w_best  = 2'd3;
    w_win   = 2'd0;
    w_c     = 2'd0;
    for (int k = 0; k < 3; k++) begin
      w_c = w_ord[2*k +: 2];
      if (w_cand[w_c] && (!w_found || slv_prio_i[2*w_c +: 2] < w_best)) begin
        w_found = 1'b1;
        w_best  = slv_prio_i[2*w_c +: 2];
        w_win   = w_c;
      end
    end
  end

  assign w_len_dec   = dec_len(slv_len_i[3*w_win +: 3]);
  assign w_take      = r_state == S_IDLE && |w_cand;
  assign w_data      = r_chid == 2'd0 ? slv0_data_i : r_chid == 2'd1 ? slv1_data_i : slv2_data_i;
  assign w_xfer      = r_state == S_XFER && slv_val_i[r_chid];
  assign w_last_word = r_cnt == r_len - LW'(1);
  assign slv_ack_o   = w_xfer ? 3'b001 << r_chid : 3'b000;

  always_comb begin
    w_next = r_state;
`ifdef MCDF_ARB_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    case (r_state)
      S_IDLE: w_next = |w_cand ? S_REQ : S_IDLE;
      S_REQ: begin
        if (fmt_grant_i) w_next = S_XFER;
`ifdef MCDF_ARB_TIMEOUT_EN
        else if (r_to_cnt == 10'd1022) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
`endif
      end
      S_XFER: w_next = w_xfer && w_last_word ? S_IDLE : S_XFER;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_chid  <= 2'd0;
      r_last  <= 2'd2;
      r_len   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_val   <= 1'b0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_chid <= w_win;
        r_last <= w_win;
        r_len  <= w_len_dec;
      end
      if (w_xfer) begin
        r_data <= w_data;
        r_cnt  <= w_last_word ? '0 : r_cnt + LW'(1);
      end
      r_val   <= w_xfer;
      r_start <= w_xfer && r_cnt == '0;
      r_end   <= w_xfer && w_last_word;
    end
  end

`ifdef MCDF_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt  <= r_state == S_REQ && w_next == S_REQ ? r_to_cnt + 10'd1 : '0;
      r_timeout <= w_timeout;
    end
  end
  assign arb_timeout_o = r_timeout;
`else
  assign arb_timeout_o = 1'b0;
`endif

  assign fmt_req_o    = r_state == S_REQ;
  assign fmt_chid_o   = r_chid;
  assign fmt_length_o = r_len;
  assign fmt_val_o    = r_val;
  assign fmt_data_o   = r_data;
  assign fmt_start_o  = r_start;
  assign fmt_end_o    = r_end;
endmodule

// File: tb/tb_mcdf_pkt_arbiter.sv
// tb_mcdf_pkt_arbiter: scoreboard bench with a packet-level reference model of the arbiter.
module tb_mcdf_pkt_arbiter;
  localparam int DW = 32;
  localparam int LW = 6;

  logic          clk_i = 1'b0, rstn_i = 1'b0;
  logic [2:0]    slv_en_i = '0, slv_req_i = '0, slv_val_i = '0, slv_ack_o;
  logic [5:0]    slv_prio_i = '0;
  logic [8:0]    slv_len_i = '0;
  logic [DW-1:0] slv0_data_i, slv1_data_i, slv2_data_i, fmt_data_o;
  logic          fmt_req_o, fmt_grant_i = 1'b0, fmt_val_o, fmt_start_o, fmt_end_o, arb_timeout_o;
  logic [1:0]    fmt_chid_o;
  logic [LW-1:0] fmt_length_o;

  mcdf_pkt_arbiter #(.DW(DW), .LW(LW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .slv_en_i(slv_en_i), .slv_req_i(slv_req_i),
    .slv_prio_i(slv_prio_i), .slv_len_i(slv_len_i), .slv0_data_i(slv0_data_i),
    .slv1_data_i(slv1_data_i), .slv2_data_i(slv2_data_i), .slv_val_i(slv_val_i),
    .slv_ack_o(slv_ack_o), .fmt_req_o(fmt_req_o), .fmt_grant_i(fmt_grant_i),
    .fmt_chid_o(fmt_chid_o), .fmt_length_o(fmt_length_o), .fmt_val_o(fmt_val_o),
    .fmt_data_o(fmt_data_o), .fmt_start_o(fmt_start_o), .fmt_end_o(fmt_end_o),
    .arb_timeout_o(arb_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int ch; int len; int seq;} pkt_t;
  pkt_t pkt_q[$];
  pkt_t cur;
  int   n_chk = 0, n_fail = 0;
  int   val_pct = 100, g_delay = 3, rq_cnt = 0;
  bit   rand_g = 0, noise = 0, m_req = 0, have_cur = 0, prev_req = 0;
  int   hdr_cnt = 0, done_pkts = 0, pushed = 0, widx = 0;
  int   m_seq[3] = '{0, 0, 0};
  int   ack_cnt[3] = '{0, 0, 0};
  logic [29:0] seq[3] = '{default: '0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // channel FIFO heads: each pop exposes the next sequence number
  assign slv0_data_i = {2'd0, seq[0]};
  assign slv1_data_i = {2'd1, seq[1]};
  assign slv2_data_i = {2'd2, seq[2]};
  always @(posedge clk_i)
    for (int c = 0; c < 3; c++)
      if (rstn_i && slv_ack_o[c]) begin
        seq[c]     <= seq[c] + 30'd1;
        ack_cnt[c] <= ack_cnt[c] + 1;
      end

  function automatic int dec_len(input logic [2:0] code);
    return code == 0 ? 4 : code == 1 ? 8 : code == 2 ? 16 : 32;
  endfunction

  function automatic int pick(input logic [2:0] cand, input logic [5:0] prio, input int last);
    int best = -1;
    for (int k = 1; k <= 3; k++) begin
      int c = (last + k) % 3;
      if (cand[c] && (best < 0 || prio[2*c +: 2] < prio[2*best +: 2])) best = c;
    end
    return best;
  endfunction

  // reference model: one iteration per packet, sampling inputs at the clock edge
  initial begin
    int last = 2, w, l, n;
    logic [2:0] cand;
    wait (rstn_i);
    forever begin
      @(posedge clk_i);
      cand = slv_en_i & slv_req_i;
      if (cand == 3'b000) continue;
      w = pick(cand, slv_prio_i, last);
      l = dec_len(slv_len_i[3*w +: 3]);
      last = w;
      pkt_q.push_back('{ch: w, len: l, seq: m_seq[w]});
      m_seq[w] += l;
      pushed++;
      m_req = 1;
      do @(posedge clk_i); while (!fmt_grant_i);
      m_req = 0;
      n = 0;
      while (n < l) begin
        @(posedge clk_i);
        if (slv_val_i[w]) n++;
      end
    end
  end

  // val and grant driver
  initial forever begin
    @(negedge clk_i);
    if (!rstn_i) continue;
    for (int c = 0; c < 3; c++) slv_val_i[c] = $urandom_range(99) < val_pct;
    if (fmt_req_o) begin
      rq_cnt++;
      fmt_grant_i = rq_cnt >= g_delay;
    end else begin
      rq_cnt = 0;
      fmt_grant_i = noise && $urandom_range(3) == 0;
      if (rand_g) g_delay = $urandom_range(1, 5);
    end
  end

  // monitor
  initial forever begin
    @(negedge clk_i);
    if (!rstn_i) continue;
    chk("req_phase", fmt_req_o, m_req);
    if (fmt_req_o && !prev_req) begin
      hdr_cnt++;
      chk("hdr_expected", pkt_q.size() > 0, 1);
      if (pkt_q.size() > 0) begin
        cur = pkt_q.pop_front();
        have_cur = 1;
        chk("hdr_chid", fmt_chid_o, cur.ch);
        chk("hdr_length", fmt_length_o, cur.len);
        chk("hdr_prev_done", widx, 0);
        chk("timeout_idle", arb_timeout_o, 0);
        widx = 0;
      end
    end
    prev_req = fmt_req_o;
    if (fmt_val_o) begin
      chk("val_with_hdr", have_cur, 1);
      if (have_cur) begin
        logic [29:0] s;
        s = 30'(cur.seq + widx);
        chk("data", fmt_data_o, {cur.ch[1:0], s});
        chk("start", fmt_start_o, widx == 0);
        chk("end", fmt_end_o, widx == cur.len - 1);
        widx++;
        if (widx == cur.len) begin
          widx = 0;
          have_cur = 0;
          done_pkts++;
        end
      end
    end else chk("marks_idle", {fmt_start_o, fmt_end_o}, 2'b00);
  end

  task automatic wait_hdr(input int n);
    int tgt = hdr_cnt + n;
    int t = 0;
    while (hdr_cnt < tgt && t < 3000) begin @(negedge clk_i); t++; end
    chk("wait_hdr_timeout", hdr_cnt >= tgt, 1);
  endtask

  task automatic drain();
    int t = 0;
    slv_req_i = '0;
    while ((done_pkts != pushed || m_req) && t < 3000) begin @(negedge clk_i); t++; end
    chk("drain_timeout", done_pkts == pushed, 1);
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_req", fmt_req_o, 0);
    chk("rst_val", fmt_val_o, 0);
    chk("rst_start_end", {fmt_start_o, fmt_end_o}, 0);
    chk("rst_chid", fmt_chid_o, 0);
    chk("rst_length", fmt_length_o, 0);
    chk("rst_data", fmt_data_o, 0);
    chk("rst_timeout", arb_timeout_o, 0);
    rstn_i = 1'b1;
    // single ch1 packet, length 4, grant after 3 REQ cycles
    slv_en_i = 3'b111; slv_prio_i = '0; slv_len_i = '0; slv_req_i = 3'b010;
    wait_hdr(1);
    drain();
    // ch1/ch2 tie at prio 1 beat ch0 at prio 2
    slv_prio_i = 6'b01_01_10; slv_req_i = 3'b111;
    wait_hdr(4);
    drain();
    // equal priority rotation, length 8, grant noise outside REQ
    slv_prio_i = '0; slv_len_i = {3'd1, 3'd1, 3'd1}; noise = 1; slv_req_i = 3'b111;
    wait_hdr(4);
    drain();
    // ch2 length 16 with stalls, config changed mid-packet
    val_pct = 60; slv_len_i = {3'd2, 3'd0, 3'd0}; slv_req_i = 3'b100;
    wait_hdr(1);
    slv_len_i = '0; slv_prio_i = 6'b00_11_11;
    drain();
    // disabled channel never requests until enabled
    slv_prio_i = '0; slv_en_i = 3'b110; slv_req_i = 3'b001;
    repeat (10) @(negedge clk_i);
    chk("disabled_no_req", fmt_req_o, 0);
    slv_en_i = 3'b111;
    @(negedge clk_i);
    chk("enabled_req", fmt_req_o, 1);
    drain();
    // grant withheld: REQ must wait, no timeout in default build
    g_delay = 60; slv_req_i = 3'b010;
    wait_hdr(1);
    repeat (30) @(negedge clk_i);
    chk("req_held", fmt_req_o, 1);
    chk("no_timeout", arb_timeout_o, 0);
    g_delay = 3;
    drain();
    // random traffic
    rand_g = 1; val_pct = 75;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      if ($urandom_range(9) == 0) begin
        slv_en_i   = 3'($urandom);
        slv_req_i  = 3'($urandom);
        slv_prio_i = 6'($urandom);
        slv_len_i  = 9'($urandom);
      end
    end
    drain();
    for (int c = 0; c < 3; c++) chk("ack_total", ack_cnt[c], m_seq[c]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
